// File: rtl/wb_pkg.sv
// wb_pkg: load-type encodings and the long-latency result queue entry shared by
// the writeback arbiter files. Queue entry fields are sized for widths up to 32/5.
`default_nettype none
package wb_pkg;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;

  localparam int unsigned WB_DATA_MAX = 32;
  localparam int unsigned WB_RD_MAX   = 5;

  typedef struct packed {
    logic                   live;
    logic [WB_RD_MAX-1:0]   rd;
    logic [WB_DATA_MAX-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: main-pipe result, MUL/DIV offer and regfile write port bundle.
// Revision: 1.0
`default_nettype none
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int MD_DEPTH   = 4
) ();

  logic                          MEM_VALID;
  logic [2:0]                    MEM_FUNC3;
  logic                          MEM_WRITE_ENABLE;
  logic                          MEM_DATA_MEM_SELECT;
  logic [DATA_WIDTH-1:0]         MEM_JAL_SELECTED;
  logic [DATA_WIDTH-1:0]         MEM_DATA_OUT;
  logic [RD_WIDTH-1:0]           MEM_RD;
  logic                          MD_VALID;
  logic [DATA_WIDTH-1:0]         MD_RESULT;
  logic [RD_WIDTH-1:0]           MD_RD;
  logic                          MD_READY;
  logic                          WB_WRITE_ENABLE;
  logic [DATA_WIDTH-1:0]         WB_WRITE_DATA;
  logic [RD_WIDTH-1:0]           WB_RD;
  logic [$clog2(MD_DEPTH):0]     MD_PENDING;

  modport slave (
    input  MEM_VALID, MEM_FUNC3, MEM_WRITE_ENABLE, MEM_DATA_MEM_SELECT,
           MEM_JAL_SELECTED, MEM_DATA_OUT, MEM_RD, MD_VALID, MD_RESULT, MD_RD,
    output MD_READY, WB_WRITE_ENABLE, WB_WRITE_DATA, WB_RD, MD_PENDING
  );

  modport master (
    output MEM_VALID, MEM_FUNC3, MEM_WRITE_ENABLE, MEM_DATA_MEM_SELECT,
           MEM_JAL_SELECTED, MEM_DATA_OUT, MEM_RD, MD_VALID, MD_RESULT, MD_RD,
    input  MD_READY, WB_WRITE_ENABLE, WB_WRITE_DATA, WB_RD, MD_PENDING
  );

endinterface
`default_nettype wire

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load data extension selected by func3.
// Revision: 1.0
`default_nettype none
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_func3)
      FUNC3_LB:  o_data = {{(DATA_WIDTH-8){i_data[7]}}, i_data[7:0]};
      FUNC3_LH:  o_data = {{(DATA_WIDTH-16){i_data[15]}}, i_data[15:0]};
      FUNC3_LBU: o_data = {{(DATA_WIDTH-8){1'b0}}, i_data[7:0]};
      FUNC3_LHU: o_data = {{(DATA_WIDTH-16){1'b0}}, i_data[15:0]};
      FUNC3_LW:  o_data = i_data;
      default:   o_data = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
// wb_arbiter: regfile write-port arbiter; main pipe always wins, MUL/DIV results
// queue and drain in idle cycles. Optional macro WB_ARBITER_BYPASS_EN. Revision: 1.0
`default_nettype none
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int MD_DEPTH   = 4
) (
  input  logic          CLK,
  input  logic          RST,
  wb_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(MD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             queue_q [MD_DEPTH];
  wb_entry_t             queue_d [MD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wb_we_q, wb_we_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [RD_WIDTH-1:0]   wb_rd_q, wb_rd_d;

  logic [DATA_WIDTH-1:0] aligned_data;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  main_wr;
  logic                  md_ready;
  logic                  md_live;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  head_wr;
  wb_entry_t             head;

  wb_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_func3 (bus.MEM_FUNC3),
    .i_data  (bus.MEM_DATA_OUT),
    .o_data  (aligned_data)
  );

  always_comb begin
    main_data = bus.MEM_DATA_MEM_SELECT ? aligned_data : bus.MEM_JAL_SELECTED;
    main_wr   = bus.MEM_VALID && bus.MEM_WRITE_ENABLE && (bus.MEM_RD != '0);
    md_ready  = (count_q < CNT_W'(MD_DEPTH));
    md_live   = bus.MD_VALID && md_ready && (bus.MD_RD != '0);
`ifdef WB_ARBITER_BYPASS_EN
    bypass    = md_live && (count_q == '0) && !main_wr;
`else
    bypass    = 1'b0;
`endif
    push      = md_live && !bypass;
    head      = queue_q[rd_ptr_q];
    // Dead heads retire every cycle; live heads only when the port is free.
    pop       = (count_q != '0) && (!head.live || !main_wr);
    head_wr   = (count_q != '0) && head.live && !main_wr;
  end

  always_comb begin
    wb_we_d   = 1'b0;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    if (main_wr) begin
      wb_we_d   = 1'b1;
      wb_data_d = main_data;
      wb_rd_d   = bus.MEM_RD;
    end else if (head_wr) begin
      wb_we_d   = 1'b1;
      wb_data_d = head.data[DATA_WIDTH-1:0];
      wb_rd_d   = head.rd[RD_WIDTH-1:0];
    end else if (bypass) begin
      wb_we_d   = 1'b1;
      wb_data_d = bus.MD_RESULT;
      wb_rd_d   = bus.MD_RD;
    end
  end

  always_comb begin
    queue_d = queue_q;
    // A main write is younger than anything queued for the same register.
    if (main_wr) begin
      for (int i = 0; i < MD_DEPTH; i++) begin
        if (queue_q[i].rd == WB_RD_MAX'(bus.MEM_RD)) begin
          queue_d[i].live = 1'b0;
        end
      end
    end
    // Applied after the kill so a same-cycle arrival stays live.
    if (push) begin
      queue_d[wr_ptr_q].live = 1'b1;
      queue_d[wr_ptr_q].rd   = WB_RD_MAX'(bus.MD_RD);
      queue_d[wr_ptr_q].data = WB_DATA_MAX'(bus.MD_RESULT);
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MD_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      queue_q   <= queue_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign bus.MD_READY        = md_ready;
  assign bus.MD_PENDING      = count_q;
  assign bus.WB_WRITE_ENABLE = wb_we_q;
  assign bus.WB_WRITE_DATA   = wb_data_q;
  assign bus.WB_RD           = wb_rd_q;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register write data width.
REQ-002 The block SHALL have parameter RD_WIDTH, default 5, meaning destination register index width.
REQ-003 The block SHALL have parameter MD_DEPTH, default 4 (power of two, >=2), meaning long-latency result queue depth.
REQ-004 The block SHALL have port CLK, input, 1, meaning the single clock; all state on rising edge.
REQ-005 The block SHALL have port RST, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port MEM_VALID, input, 1, meaning a main-pipe instruction is present.
REQ-007 The block SHALL have ports MEM_FUNC3 (in, 3), MEM_WRITE_ENABLE (in, 1), MEM_DATA_MEM_SELECT (in, 1), MEM_JAL_SELECTED (in, DATA_WIDTH), MEM_DATA_OUT (in, DATA_WIDTH) and MEM_RD (in, RD_WIDTH), meaning the main-pipe result fields.
REQ-008 The block SHALL have ports MD_VALID (in, 1), MD_RESULT (in, DATA_WIDTH) and MD_RD (in, RD_WIDTH), meaning a multi-cycle MUL/DIV result offer.
REQ-009 The block SHALL have port MD_READY, output, 1, meaning a queue slot is free.
REQ-010 The block SHALL have ports WB_WRITE_ENABLE (out, 1), WB_WRITE_DATA (out, DATA_WIDTH) and WB_RD (out, RD_WIDTH), meaning the registered regfile write port.
REQ-011 The block SHALL have port MD_PENDING, output, $clog2(MD_DEPTH)+1, meaning queue occupancy.

Function
REQ-012 Main data: MEM_DATA_MEM_SELECT=0 SHALL select MEM_JAL_SELECTED; =1 SHALL select the load-aligned MEM_DATA_OUT.
REQ-013 Load align: 000 sign-extends byte[7:0]; 001 sign-extends half[15:0]; 100/101 zero-extend byte/half; 010 and all other codes pass through.
REQ-014 Main write occurs when MEM_VALID && MEM_WRITE_ENABLE && MEM_RD!=0; it SHALL always win the write port, with no main-pipe stall.
REQ-015 Handshake: MD transfer occurs when MD_VALID && MD_READY; MD_READY = occupancy < MD_DEPTH, combinational from state only.
REQ-016 Accepted MD results with MD_RD=0 SHALL be dropped, neither queued nor written.
REQ-017 Queue drains in FIFO order; the head SHALL be written only in a cycle with no main write.
REQ-018 Ordering kill: a main write whose MEM_RD matches a queued live entry SHALL clear that entry's live bit in the same cycle, because the main result is younger.
REQ-019 Dead head entries SHALL pop without a write, one per cycle, regardless of main activity.
REQ-020 Push and pop in one cycle SHALL leave occupancy unchanged; pointers wrap modulo MD_DEPTH.
REQ-021 Latency: WB_* outputs SHALL be registered, 1 cycle after the selecting inputs; WB_WRITE_ENABLE is 0 in idle cycles, and WB_WRITE_DATA and WB_RD then hold their previous values.
REQ-022 An arriving MD result whose MD_RD equals a same-cycle main MEM_RD SHALL be queued live, since the MD result is younger.

Reset
REQ-023 Asserting RST SHALL immediately clear WB_WRITE_ENABLE, WB_WRITE_DATA, WB_RD, pointers, live bits and MD_PENDING to 0, so MD_READY=1.
REQ-024 Reset mid-drain SHALL discard queued entries, with no write emitted after release until a new input arrives.

Configuration
REQ-025 With macro WB_ARBITER_BYPASS_EN defined, an accepted MD result SHALL be written directly in the next cycle without queue storage when the queue is empty and there is no main write.
REQ-026 Without WB_ARBITER_BYPASS_EN, every accepted MD result SHALL pass through the queue, giving a minimum latency of 2 cycles.

Structure
REQ-027 Package wb_pkg SHALL hold the FUNC3 load encodings (LB, LH, LW, LBU, LHU) and the queue entry typedef {live, rd, data}.
REQ-028 Load alignment SHALL be a sub-module wb_load_align, combinational and DATA_WIDTH-parametrised.

Verification
REQ-029 The bench SHALL check: main LB with MEM_DATA_OUT=0x000000F0, rd=3, select=1 -> next cycle WE=1, rd=3, data=0xFFFFFFF0; LBU -> 0x000000F0.
REQ-030 The bench SHALL check: MD rd=7 value 5 offered for 5 cycles while main writes rd=1,2,3,4,5 continuously -> MD_READY=0 after 4 accepts, MD_PENDING=4, then the queue drains rd=7 in the first idle cycle.
REQ-031 The bench SHALL check: queue rd=9 value 0x11, then a main write rd=9 value 0x22 before drain -> only 0x22 written to rd=9, the dead entry pops silently and MD_PENDING returns to 0.
REQ-032 The bench SHALL check: MD rd=0 accepted -> no write and MD_PENDING unchanged; main write rd=0 -> WE stays 0.
REQ-033 The bench SHALL check: with the queue at 3 entries, assert RST mid-drain -> outputs 0 immediately, MD_READY=1, and no stale write after release.
REQ-034 The bench SHALL check: idle pipe, MD rd=4 value 0xAB -> WE=1 after 1 cycle with WB_ARBITER_BYPASS_EN, and after 2 cycles without it.
